// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack-style CPU: FSM states, instruction field
// positions, jump decode and the default switch-port address.
package hack_pkg;

  typedef enum logic {FETCH, EXEC} state_t;

  localparam int unsigned BIT_CI = 15;
  localparam int unsigned BIT_A  = 12;
  localparam int unsigned BIT_ZX = 11;
  localparam int unsigned BIT_NX = 10;
  localparam int unsigned BIT_ZY = 9;
  localparam int unsigned BIT_NY = 8;
  localparam int unsigned BIT_F  = 7;
  localparam int unsigned BIT_NO = 6;
  localparam int unsigned BIT_D1 = 5;
  localparam int unsigned BIT_D2 = 4;
  localparam int unsigned BIT_D3 = 3;
  localparam int unsigned BIT_J1 = 2;
  localparam int unsigned BIT_J3 = 0;

  localparam logic [2:0] JMP_ALWAYS = 3'b111;

  localparam logic [14:0] SW_ADDR_DEF = 15'h6000;

  function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
    if (j == JMP_ALWAYS) return 1'b1;
    return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_alu.sv
// Purely combinational Hack ALU: zero/negate each operand, add or AND, optionally
// negate the result, and flag zero/negative.
module hack_alu #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              zx,
  input  logic              nx,
  input  logic              zy,
  input  logic              ny,
  input  logic              f,
  input  logic              no,
  output logic [DATA_W-1:0] out,
  output logic              zr,
  output logic              ng
);

  logic [DATA_W-1:0] x_z, x_n, y_z, y_n, res;

  always_comb begin
    x_z = zx ? '0 : x;
    x_n = nx ? ~x_z : x_z;
    y_z = zy ? '0 : y;
    y_n = ny ? ~y_z : y_z;
    res = f ? (x_n + y_n) : (x_n & y_n);
    out = no ? ~res : res;
    zr  = (out == '0);
    ng  = out[DATA_W-1];
  end

endmodule

// File: rtl/hack_cpu.sv
// Hack-style CPU core: two-cycle FETCH/EXEC FSM, A/D/PC registers and jump logic.
// Optional HACK_SW_IO_EN maps the board switches onto the M operand at SW_ADDR.
module hack_cpu
  import hack_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 15,
  parameter int unsigned       DATA_W  = 16,
  parameter logic [ADDR_W-1:0] SW_ADDR = SW_ADDR_DEF
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [DATA_W-1:0] inst,
  input  logic [DATA_W-1:0] in_m,
  input  logic [3:0]        SW,
  output logic [DATA_W-1:0] out_m,
  output logic              write_m,
  output logic [ADDR_W-1:0] data_addr,
  output logic [ADDR_W-1:0] inst_addr
);

  state_t            state_q;
  logic [DATA_W-1:0] a_q, d_q;
  logic [ADDR_W-1:0] pc_q;

  logic [DATA_W-1:0] m_val, y_val, alu_out;
  logic              alu_zr, alu_ng, is_c, jump;

`ifdef HACK_SW_IO_EN
  assign m_val = (a_q[ADDR_W-1:0] == SW_ADDR) ? {{(DATA_W-4){1'b0}}, SW} : in_m;
  logic unused_bits;
  assign unused_bits = ^inst[14:13];
`else
  assign m_val = in_m;
  logic unused_bits;
  assign unused_bits = ^{SW, SW_ADDR, inst[14:13]};
`endif

  assign y_val = inst[BIT_A] ? m_val : a_q;

  hack_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .x  (d_q),
    .y  (y_val),
    .zx (inst[BIT_ZX]),
    .nx (inst[BIT_NX]),
    .zy (inst[BIT_ZY]),
    .ny (inst[BIT_NY]),
    .f  (inst[BIT_F]),
    .no (inst[BIT_NO]),
    .out(alu_out),
    .zr (alu_zr),
    .ng (alu_ng)
  );

  assign is_c      = (state_q == EXEC) && inst[BIT_CI];
  assign jump      = jump_taken(inst[BIT_J1:BIT_J3], alu_zr, alu_ng);
  assign write_m   = is_c && inst[BIT_D3];
  // ROM output is not meaningful while held in reset, so the write data is forced low.
  assign out_m     = resetN ? alu_out : '0;
  assign data_addr = a_q[ADDR_W-1:0];
  assign inst_addr = pc_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= FETCH;
      a_q     <= '0;
      d_q     <= '0;
      pc_q    <= '0;
    end else begin
      unique case (state_q)
        FETCH: state_q <= EXEC;
        EXEC: begin
          state_q <= FETCH;
          if (!inst[BIT_CI]) begin
            a_q  <= {{(DATA_W-ADDR_W){1'b0}}, inst[ADDR_W-1:0]};
            pc_q <= pc_q + 1'b1;
          end else begin
            if (inst[BIT_D1]) a_q <= alu_out;
            if (inst[BIT_D2]) d_q <= alu_out;
            // Jump target and M address both use the A value from before this update.
            pc_q <= jump ? a_q[ADDR_W-1:0] : pc_q + 1'b1;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu.sv
// Directed bench for hack_cpu with small behavioural ROM/RAM models.
module tb_hack_cpu;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [15:0] inst, in_m, out_m;
  logic [3:0]  SW = 4'h0;
  logic        write_m;
  logic [14:0] data_addr, inst_addr;

  logic [15:0] rom [0:31];
  logic [15:0] ram [0:31];

  int errors = 0;
  int checks = 0;

  hack_cpu dut (
    .clk      (clk),
    .resetN   (resetN),
    .inst     (inst),
    .in_m     (in_m),
    .SW       (SW),
    .out_m    (out_m),
    .write_m  (write_m),
    .data_addr(data_addr),
    .inst_addr(inst_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    inst <= rom[inst_addr[4:0]];
    in_m <= ram[data_addr[4:0]];
    if (write_m) ram[data_addr[4:0]] <= out_m;
  end

  task automatic half();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) begin
      rom[i] = 16'h0000;
      ram[i] <= 16'h0000;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    clear_mem();
    for (int i = 0; i < 32; i++) rom[i] = 16'(i);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    checks++;
    if (inst_addr !== 15'd0) begin
      errors++; $display("FAIL reset_pc: got %h want 0000", inst_addr);
    end
    checks++;
    if (write_m !== 1'b0) begin
      errors++; $display("FAIL reset_write: got %b want 0", write_m);
    end
    checks++;
    if (out_m !== 16'h0000) begin
      errors++; $display("FAIL reset_out: got %h want 0000", out_m);
    end
    @(negedge clk);
    resetN = 1'b1;
    half();
    checks++;
    if (inst_addr !== 15'd0 || write_m !== 1'b0) begin
      errors++; $display("FAIL first_exec: got pc %h wr %b want 0000 0", inst_addr, write_m);
    end
    half();
    checks++;
    if (inst_addr !== 15'd1 || data_addr !== 15'd0) begin
      errors++; $display("FAIL pc_step1: got pc %h a %h want 0001 0000", inst_addr, data_addr);
    end
    half(); half();
    checks++;
    if (inst_addr !== 15'd2 || data_addr !== 15'd1) begin
      errors++; $display("FAIL pc_step2: got pc %h a %h want 0002 0001", inst_addr, data_addr);
    end
  endtask

  task automatic test_store();
    int wcount = 0;
    logic [14:0] waddr = '0;
    logic [15:0] wdata = '0;
    clear_mem();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0003; rom[3] = 16'hE308;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      half();
      if (write_m === 1'b1) begin
        wcount++; waddr = data_addr; wdata = out_m;
      end
    end
    checks++;
    if (wcount != 1) begin
      errors++; $display("FAIL store_count: got %0d want 1", wcount);
    end
    checks++;
    if (waddr !== 15'd3 || wdata !== 16'd5) begin
      errors++; $display("FAIL store_val: got addr %h data %h want 0003 0005", waddr, wdata);
    end
    checks++;
    if (ram[3] !== 16'd5) begin
      errors++; $display("FAIL store_ram: got %h want 0005", ram[3]);
    end
  endtask

  task automatic test_alu_flags();
    clear_mem();
    ram[7] <= 16'd9;
    rom[0] = 16'h0007; rom[1] = 16'hFDD0; rom[2] = 16'hE390;
    rom[3] = 16'h0000; rom[4] = 16'hEC10; rom[5] = 16'hE390;
    rom[6] = 16'h0001; rom[7] = 16'hEC10; rom[8] = 16'hE390;
    do_reset();
    repeat (3) half();
    checks++;
    if (out_m !== 16'd10) begin
      errors++; $display("FAIL m_plus1: got %h want 000a", out_m);
    end
    repeat (2) half();
    checks++;
    if (out_m !== 16'd9 || dut.u_alu.zr !== 1'b0 || dut.u_alu.ng !== 1'b0) begin
      errors++; $display("FAIL d_minus1_pos: got %h zr %b ng %b want 0009 0 0",
                         out_m, dut.u_alu.zr, dut.u_alu.ng);
    end
    repeat (6) half();
    checks++;
    if (out_m !== 16'hFFFF || dut.u_alu.zr !== 1'b0 || dut.u_alu.ng !== 1'b1) begin
      errors++; $display("FAIL d_minus1_neg: got %h zr %b ng %b want ffff 0 1",
                         out_m, dut.u_alu.zr, dut.u_alu.ng);
    end
    repeat (6) half();
    checks++;
    if (out_m !== 16'h0000 || dut.u_alu.zr !== 1'b1 || dut.u_alu.ng !== 1'b0) begin
      errors++; $display("FAIL d_minus1_zero: got %h zr %b ng %b want 0000 1 0",
                         out_m, dut.u_alu.zr, dut.u_alu.ng);
    end
  endtask

  task automatic test_jump();
    clear_mem();
    rom[0]  = 16'h0004; rom[1]  = 16'hEA87;
    rom[4]  = 16'h0000; rom[5]  = 16'hEC10; rom[6]  = 16'h000A; rom[7]  = 16'hE302;
    rom[10] = 16'h0001; rom[11] = 16'hEC10; rom[12] = 16'h0014; rom[13] = 16'hE302;
    rom[14] = 16'h7FFF; rom[15] = 16'hEA87; rom[31] = 16'h0000;
    do_reset();
    repeat (4) half();
    checks++;
    if (inst_addr !== 15'd4) begin
      errors++; $display("FAIL jmp: got %h want 0004", inst_addr);
    end
    repeat (8) half();
    checks++;
    if (inst_addr !== 15'd10) begin
      errors++; $display("FAIL jeq_taken: got %h want 000a", inst_addr);
    end
    repeat (8) half();
    checks++;
    if (inst_addr !== 15'd14) begin
      errors++; $display("FAIL jeq_not_taken: got %h want 000e", inst_addr);
    end
    repeat (4) half();
    checks++;
    if (inst_addr !== 15'h7FFF) begin
      errors++; $display("FAIL jmp_top: got %h want 7fff", inst_addr);
    end
    repeat (2) half();
    checks++;
    if (inst_addr !== 15'h0000) begin
      errors++; $display("FAIL pc_wrap: got %h want 0000", inst_addr);
    end
  endtask

  task automatic test_am_update();
    clear_mem();
    ram[2] <= 16'd6;
    rom[0] = 16'h0002; rom[1] = 16'hFDE8;
    do_reset();
    repeat (3) half();
    checks++;
    if (write_m !== 1'b1 || data_addr !== 15'd2 || out_m !== 16'd7) begin
      errors++; $display("FAIL am_write: got wr %b addr %h data %h want 1 0002 0007",
                         write_m, data_addr, out_m);
    end
    half();
    checks++;
    if (data_addr !== 15'd7 || ram[2] !== 16'd7) begin
      errors++; $display("FAIL am_after: got a %h ram2 %h want 0007 0007", data_addr, ram[2]);
    end
  endtask

  task automatic test_sw_io();
    logic [15:0] exp_m;
`ifdef HACK_SW_IO_EN
    exp_m = 16'h000A;
`else
    exp_m = 16'h1234;
`endif
    clear_mem();
    SW = 4'hA;
    ram[0] <= 16'h1234;  // bench RAM aliases 0x6000 onto word 0
    rom[0] = 16'h6000; rom[1] = 16'hFC10;
    do_reset();
    repeat (3) half();
    checks++;
    if (data_addr !== 15'h6000 || out_m !== exp_m) begin
      errors++; $display("FAIL sw_read: got a %h m %h want 6000 %h", data_addr, out_m, exp_m);
    end
  endtask

  task automatic test_reset_mid_exec();
    clear_mem();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0003; rom[3] = 16'hE308;
    do_reset();
    repeat (7) half();
    checks++;
    if (write_m !== 1'b1) begin
      errors++; $display("FAIL abort_pre: got wr %b want 1", write_m);
    end
    #1 resetN = 1'b0;
    #1;
    checks++;
    if (write_m !== 1'b0 || inst_addr !== 15'd0 || data_addr !== 15'd0) begin
      errors++; $display("FAIL abort_regs: got wr %b pc %h a %h want 0 0000 0000",
                         write_m, inst_addr, data_addr);
    end
    half();
    checks++;
    if (ram[3] !== 16'h0000) begin
      errors++; $display("FAIL abort_ram: got %h want 0000", ram[3]);
    end
    resetN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_store();
    test_alu_flags();
    test_jump();
    test_am_update();
    test_sw_io();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
